// File: rtl/atm_pin_change_ctrl_if.sv
// -----------------------------------------------------------------------------
// atm_pin_change_ctrl_if
//   Bundles the request, response and table-configuration signals of the ATM
//   PIN-change engine.
//
//   master : keypad/session front-end (drives requests and table writes,
//            consumes responses)
//   slave  : atm_pin_change_ctrl
//
//   Request  : req_valid, req_ready, req_card, req_old_pin, req_new_pin
//   Response : rsp_valid, rsp_ready, rsp_status[2:0], rsp_index
//   Config   : cfg_we, cfg_idx, cfg_card, cfg_pin
//
//   Parameters: CARD_W, PIN_W, IDX_W (must equal $clog2(N_USERS) of the engine)
// -----------------------------------------------------------------------------
interface atm_pin_change_ctrl_if #(
    parameter int CARD_W = 10,
    parameter int PIN_W  = 11,
    parameter int IDX_W  = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [CARD_W-1:0] req_card;
    logic [PIN_W-1:0]  req_old_pin;
    logic [PIN_W-1:0]  req_new_pin;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_status;
    logic [IDX_W-1:0]  rsp_index;

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [CARD_W-1:0] cfg_card;
    logic [PIN_W-1:0]  cfg_pin;

    modport master (
        output req_valid, req_card, req_old_pin, req_new_pin,
        output rsp_ready,
        output cfg_we, cfg_idx, cfg_card, cfg_pin,
        input  req_ready, rsp_valid, rsp_status, rsp_index
    );

    modport slave (
        input  req_valid, req_card, req_old_pin, req_new_pin,
        input  rsp_ready,
        input  cfg_we, cfg_idx, cfg_card, cfg_pin,
        output req_ready, rsp_valid, rsp_status, rsp_index
    );
endinterface : atm_pin_change_ctrl_if

// File: rtl/atm_pin_change_ctrl.sv
// -----------------------------------------------------------------------------
// atm_pin_change_ctrl
//   Clocked PIN-change engine. Holds a table of N_USERS entries
//   {card, pin, valid}. A request {card, old PIN, new PIN} is accepted in
//   IDLE, then the table is scanned one entry per cycle; the lowest valid
//   entry whose card matches is authenticated against the old PIN and, on
//   success, rewritten with the new PIN. A status code and the matched index
//   are returned over a valid/ready response channel.
//
//   Ports:
//     i_clk   rising-edge clock
//     i_rst   synchronous, active-high reset
//     bus     atm_pin_change_ctrl_if.slave (request / response / config)
//     o_busy  high while in SCAN, UPDATE or RESP
//
//   Status codes: 0 OK, 1 NO_CARD, 2 BAD_PIN, 3 LOCKED, 4 SAME_PIN
//
//   Optional feature macro: ATM_PIN_LOCKOUT_EN
//     defined   : per-entry saturating fail counter; an entry whose counter
//                 reaches MAX_TRIES answers LOCKED until rewritten via cfg.
//     undefined : no counters, unlimited retries, LOCKED never produced.
// -----------------------------------------------------------------------------
module atm_pin_change_ctrl #(
    parameter int N_USERS   = 8,
    parameter int CARD_W    = 10,
    parameter int PIN_W     = 11,
    parameter int MAX_TRIES = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    atm_pin_change_ctrl_if.slave bus,
    output logic                 o_busy
);
    localparam int IDX_W = $clog2(N_USERS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_USERS - 1);
    // One extra bit so the range check also works for power-of-two tables.
    localparam logic [IDX_W:0]   N_USERS_EXT = (IDX_W + 1)'(N_USERS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_UPDATE,
        S_RESP
    } state_t;

    typedef enum logic [2:0] {
        RSP_OK       = 3'd0,
        RSP_NO_CARD  = 3'd1,
        RSP_BAD_PIN  = 3'd2,
        RSP_LOCKED   = 3'd3,
        RSP_SAME_PIN = 3'd4
    } status_t;

    // ---------------------------------------------------------------------
    // State and storage
    // ---------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;

    logic [CARD_W-1:0]  r_card [N_USERS];
    logic [PIN_W-1:0]   r_pin  [N_USERS];
    logic [N_USERS-1:0] r_valid;

    logic [CARD_W-1:0]  r_req_card;
    logic [PIN_W-1:0]   r_req_old;
    logic [PIN_W-1:0]   r_req_new;

    logic [IDX_W-1:0]   r_scan_idx;
    status_t            r_rsp_status;
    logic [IDX_W-1:0]   r_rsp_index;

    // ---------------------------------------------------------------------
    // Combinational control
    // ---------------------------------------------------------------------
    logic    w_accept;
    logic    w_cfg_wr;
    logic    w_pin_wr;
    logic    w_hit;
    logic    w_pin_ok;
    logic    w_same_pin;
    logic    w_locked;
    logic    w_last;
    logic    w_scan_adv;
    logic    w_rsp_load;
    status_t w_rsp_status_d;
    logic    w_fail_inc;
    logic    w_fail_clr;
    logic    w_req_ready;
    logic    w_rsp_valid;

    assign w_accept   = bus.req_valid && (r_state == S_IDLE);
    // Table writes are only honoured in IDLE so a scan never sees an entry
    // change underneath it.
    assign w_cfg_wr   = bus.cfg_we && (r_state == S_IDLE) &&
                        ({1'b0, bus.cfg_idx} < N_USERS_EXT);
    assign w_pin_wr   = (r_state == S_UPDATE);

    assign w_hit      = r_valid[r_scan_idx] && (r_card[r_scan_idx] == r_req_card);
    assign w_pin_ok   = (r_pin[r_scan_idx] == r_req_old);
    assign w_same_pin = (r_req_new == r_req_old);
    assign w_last     = (r_scan_idx == LAST_IDX);

`ifdef ATM_PIN_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);

    logic [FAIL_W-1:0] r_fail [N_USERS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_USERS; i++) begin
                r_fail[i] <= '0;
            end
        end else begin
            // A cfg rewrite of an entry unlocks it.
            if (w_cfg_wr) begin
                r_fail[bus.cfg_idx] <= '0;
            end
            if (w_fail_inc && (r_fail[r_scan_idx] != FAIL_MAX)) begin
                r_fail[r_scan_idx] <= r_fail[r_scan_idx] + FAIL_W'(1);
            end else if (w_fail_clr) begin
                r_fail[r_scan_idx] <= '0;
            end
        end
    end

    assign w_locked = (r_fail[r_scan_idx] == FAIL_MAX);
`else
    // Without lockout the counter controls go nowhere.
    logic w_unused_lockout;
    assign w_unused_lockout = w_fail_inc | w_fail_clr | (MAX_TRIES < 1);
    assign w_locked         = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and control
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        w_state_nxt    = r_state;
        w_scan_adv     = 1'b0;
        w_rsp_load     = 1'b0;
        w_rsp_status_d = RSP_OK;
        w_fail_inc     = 1'b0;
        w_fail_clr     = 1'b0;
        w_req_ready    = 1'b0;
        w_rsp_valid    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_state_nxt = S_SCAN;
                end
            end

            S_SCAN: begin
                if (w_hit) begin
                    // Lowest matching index wins: the scan stops here.
                    w_state_nxt = S_RESP;
                    w_rsp_load  = 1'b1;
                    if (w_locked) begin
                        w_rsp_status_d = RSP_LOCKED;
                    end else if (!w_pin_ok) begin
                        w_rsp_status_d = RSP_BAD_PIN;
                        w_fail_inc     = 1'b1;
                    end else if (w_same_pin) begin
                        w_rsp_status_d = RSP_SAME_PIN;
                        w_fail_clr     = 1'b1;
                    end else begin
                        // Authenticated change: one extra cycle for the write,
                        // status is loaded on the way out of UPDATE.
                        w_state_nxt = S_UPDATE;
                        w_rsp_load  = 1'b0;
                        w_fail_clr  = 1'b1;
                    end
                end else if (w_last) begin
                    w_state_nxt    = S_RESP;
                    w_rsp_load     = 1'b1;
                    w_rsp_status_d = RSP_NO_CARD;
                end else begin
                    w_scan_adv = 1'b1;
                end
            end

            S_UPDATE: begin
                w_state_nxt    = S_RESP;
                w_rsp_load     = 1'b1;
                w_rsp_status_d = RSP_OK;
            end

            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Control datapath: valid bits, scan pointer, response registers
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid      <= '0;
            r_scan_idx   <= '0;
            r_rsp_status <= RSP_OK;
            r_rsp_index  <= '0;
        end else begin
            if (w_cfg_wr) begin
                r_valid[bus.cfg_idx] <= 1'b1;
            end

            if (w_accept) begin
                r_scan_idx <= '0;
            end else if (w_scan_adv) begin
                r_scan_idx <= r_scan_idx + 1'b1;
            end

            // The scan pointer still holds the matched entry in SCAN/UPDATE.
            if (w_rsp_load) begin
                r_rsp_status <= w_rsp_status_d;
                r_rsp_index  <= (w_rsp_status_d == RSP_NO_CARD) ? '0 : r_scan_idx;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Table contents and latched request
    // ---------------------------------------------------------------------
    // NOTE: table contents and request latches are deliberately not reset;
    // r_valid alone defines occupancy. Writes are still gated by reset so a
    // reset during UPDATE aborts the PIN write.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_cfg_wr) begin
                r_card[bus.cfg_idx] <= bus.cfg_card;
                r_pin[bus.cfg_idx]  <= bus.cfg_pin;
            end
            // cfg writes happen only in IDLE, PIN updates only in UPDATE.
            if (w_pin_wr) begin
                r_pin[r_scan_idx] <= r_req_new;
            end
            // Latched at the accept edge; a cfg write at the same edge is
            // visible to the scan since it starts a cycle later.
            if (w_accept) begin
                r_req_card <= bus.req_card;
                r_req_old  <= bus.req_old_pin;
                r_req_new  <= bus.req_new_pin;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_status = r_rsp_status;
    assign bus.rsp_index  = r_rsp_index;
    assign o_busy         = (r_state != S_IDLE);

endmodule : atm_pin_change_ctrl
